// File: rtl/data_memory_pipe_if.sv
// data_memory_pipe_if: data-bus bundle of the pipelined data memory (write port, read port,
// clear engine and parity test hook).
interface data_memory_pipe_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              wr;
    logic [ADDR_W-1:0] address_wr;
    logic [DATA_W-1:0] din;
    logic              rd;
    logic [ADDR_W-1:0] address_rd;
    logic [DATA_W-1:0] dout;
    logic              rd_valid;
    logic              clear_req;
    logic              busy;
    logic              par_inj;
    logic              par_err;
    modport master (
        output wr, address_wr, din, rd, address_rd, clear_req, par_inj,
        input  dout, rd_valid, busy, par_err
    );
    modport slave (
        input  wr, address_wr, din, rd, address_rd, clear_req, par_inj,
        output dout, rd_valid, busy, par_err
    );
endinterface

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: simple dual-port RAM with RD_LAT-cycle read pipeline, collision policy and
// zero-fill clear engine. Define PARITY_EN to store a parity bit per word and flag mismatches.
module data_memory_pipe #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 1
) (
    input logic              clk,
    input logic              areset_n,
    data_memory_pipe_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
`ifdef PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_chk
            $error("data_memory_pipe: RD_LAT must be in 1..4");
        end
    endgenerate

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nx;
    logic              w_busy;
    logic [MW-1:0]     r_mem [DEPTH];
    logic [MW-1:0]     w_wword, w_wd, w_rword;
    logic [ADDR_W-1:0] w_wa;
    logic              w_we, w_acc, w_coll;
    logic [MW-1:0]     r_pd [RD_LAT];
    logic [RD_LAT-1:0] r_pv;
    logic [DATA_W-1:0] r_dout;
    logic              r_rd_valid;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_busy     = (r_state == CLEAR);
        if (r_state == IDLE) begin
            if (bus.clear_req) begin
                w_state_nx = CLEAR;
                w_ptr_nx   = '0;
            end
        end else begin
            w_ptr_nx = r_ptr + 1'b1;
            if (&r_ptr) w_state_nx = IDLE;
        end
    end

`ifdef PARITY_EN
    assign w_wword = {^bus.din ^ bus.par_inj, bus.din};
`else
    logic w_unused_par_inj;
    assign w_unused_par_inj = bus.par_inj;
    assign w_wword          = bus.din;
`endif

    // The clear engine owns the write port while busy; an all-zero word has correct (even) parity.
    assign w_we = w_busy | bus.wr;
    assign w_wa = w_busy ? r_ptr : bus.address_wr;
    assign w_wd = w_busy ? '0 : w_wword;

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_wa] <= w_wd;
    end

    assign w_acc   = bus.rd & ~w_busy;
    assign w_coll  = (WR_FIRST != 0) && bus.wr && (bus.address_wr == bus.address_rd);
    assign w_rword = w_coll ? w_wword : r_mem[bus.address_rd];

    // Stage 0 captures the word at the read edge, so reads in flight survive a later clear.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_pv       <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pd[i] <= '0;
            r_dout     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_pv[0] <= w_acc;
            r_pd[0] <= w_rword;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
            r_rd_valid <= r_pv[RD_LAT-1];
            if (r_pv[RD_LAT-1]) r_dout <= r_pd[RD_LAT-1][DATA_W-1:0];
        end
    end

    assign bus.dout     = r_dout;
    assign bus.rd_valid = r_rd_valid;
    assign bus.busy     = w_busy;

`ifdef PARITY_EN
    logic r_par_err;
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) r_par_err <= 1'b0;
        else           r_par_err <= r_pv[RD_LAT-1] &&
                                    ((^r_pd[RD_LAT-1][DATA_W-1:0]) != r_pd[RD_LAT-1][DATA_W]);
    end
    assign bus.par_err = r_par_err;
`else
    assign bus.par_err = 1'b0;
`endif
endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: directed table, corner sequences and randomized traffic against a
// whole-array reference model of data_memory_pipe (RD_LAT=2, WR_FIRST=1).
module tb_data_memory_pipe;
    localparam int RD_LAT   = 2;
    localparam int WR_FIRST = 1;
    localparam int DEPTH    = 256;
`ifdef PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic areset_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_pipe_if #(.DATA_W(16), .ADDR_W(8)) bus ();
    data_memory_pipe #(.DATA_W(16), .ADDR_W(8), .RD_LAT(RD_LAT), .WR_FIRST(WR_FIRST)) dut (
        .clk(clk), .areset_n(areset_n), .bus(bus)
    );

    typedef struct {
        int          due;
        logic [15:0] d;
        bit          bad;
        bit          known;
    } rd_t;

    typedef struct {
        bit          wr;
        logic [7:0]  wa;
        logic [15:0] d;
        bit          rd;
        logic [7:0]  ra;
        bit          ev;
        bit          cd;
        logic [15:0] ed;
    } vec_t;

    rd_t         q[$];
    logic [15:0] mm [DEPTH];
    bit          mbad [DEPTH];
    bit          mk [DEPTH];
    int          cyc = 0;
    int          busy_left = 0;
    logic [15:0] last_d = '0;
    bit          last_k = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tbl [14];

    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
        end
    endfunction

    // One clock: drive at negedge, advance the model by the edge, check at the next negedge.
    task automatic cycle(input bit wr, input logic [7:0] wa, input logic [15:0] din,
                         input bit rd, input logic [7:0] ra, input bit clr, input bit inj);
        rd_t e;
        bit  ev;
        bus.wr = wr; bus.address_wr = wa; bus.din = din;
        bus.rd = rd; bus.address_rd = ra; bus.clear_req = clr; bus.par_inj = inj;
        cyc++;
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (rd) begin
                e.due = cyc + RD_LAT;
                if (wr && wa == ra && WR_FIRST != 0) begin
                    e.d = din; e.bad = inj; e.known = 1'b1;
                end else begin
                    e.d = mm[ra]; e.bad = mbad[ra]; e.known = mk[ra];
                end
                q.push_back(e);
            end
            if (wr) begin
                mm[wa] = din; mbad[wa] = inj; mk[wa] = 1'b1;
            end
            if (clr) begin
                busy_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) begin
                    mm[i] = '0; mbad[i] = 1'b0; mk[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        ev = (q.size() > 0) && (q[0].due == cyc);
        chk("rd_valid", bus.rd_valid, ev);
        if (ev) begin
            e = q.pop_front();
            if (e.known) begin
                chk("dout", bus.dout, e.d);
                chk("par_err", bus.par_err, PAR & e.bad);
            end
            last_d = e.d;
            last_k = e.known;
        end else begin
            chk("par_err_idle", bus.par_err, 1'b0);
            if (last_k) chk("dout_hold", bus.dout, last_d);
        end
        chk("busy", bus.busy, busy_left > 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 16'h0, 0, 8'h00, 0, 0);
    endtask

    // Async reset asserted mid-cycle; outputs must drop before any clock edge.
    task automatic do_reset();
        bus.wr = 0; bus.rd = 0; bus.clear_req = 0; bus.par_inj = 0;
        #2 areset_n = 1'b0;
        #1;
        chk("rst_dout", bus.dout, 16'h0);
        chk("rst_valid", bus.rd_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_par", bus.par_err, 1'b0);
        if (busy_left > 0) for (int i = 0; i < DEPTH; i++) mk[i] = 1'b0;
        busy_left = 0;
        q.delete();
        last_d = '0;
        last_k = 1'b1;
        @(negedge clk);
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            mm[i] = '0; mbad[i] = 1'b0; mk[i] = 1'b0;
        end
        tbl[0]  = '{1, 8'h10, 16'hA5A5, 0, 8'h00, 0, 0, 16'h0000};
        tbl[1]  = '{0, 8'h00, 16'h0000, 1, 8'h10, 0, 0, 16'h0000};
        tbl[2]  = '{1, 8'h00, 16'h0100, 0, 8'h00, 0, 0, 16'h0000};
        tbl[3]  = '{1, 8'h01, 16'h0101, 0, 8'h00, 1, 1, 16'hA5A5};
        tbl[4]  = '{1, 8'h02, 16'h0102, 0, 8'h00, 0, 1, 16'hA5A5};
        tbl[5]  = '{1, 8'h03, 16'h0103, 0, 8'h00, 0, 1, 16'hA5A5};
        tbl[6]  = '{1, 8'h20, 16'h1234, 1, 8'h20, 0, 1, 16'hA5A5};
        tbl[7]  = '{0, 8'h00, 16'h0000, 1, 8'h00, 0, 1, 16'hA5A5};
        tbl[8]  = '{0, 8'h00, 16'h0000, 1, 8'h01, 1, 1, 16'h1234};
        tbl[9]  = '{0, 8'h00, 16'h0000, 1, 8'h02, 1, 1, 16'h0100};
        tbl[10] = '{0, 8'h00, 16'h0000, 1, 8'h03, 1, 1, 16'h0101};
        tbl[11] = '{0, 8'h00, 16'h0000, 0, 8'h00, 1, 1, 16'h0102};
        tbl[12] = '{0, 8'h00, 16'h0000, 0, 8'h00, 1, 1, 16'h0103};
        tbl[13] = '{0, 8'h00, 16'h0000, 0, 8'h00, 0, 1, 16'h0103};

        bus.wr = 0; bus.address_wr = '0; bus.din = '0; bus.rd = 0; bus.address_rd = '0;
        bus.clear_req = 0; bus.par_inj = 0;
        #1;
        chk("init_dout", bus.dout, 16'h0);
        chk("init_valid", bus.rd_valid, 1'b0);
        chk("init_busy", bus.busy, 1'b0);
        chk("init_par", bus.par_err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        areset_n = 1'b1;

        // reset with reads in flight
        cycle(1, 8'h50, 16'h5555, 0, 8'h00, 0, 0);
        cycle(0, 8'h00, 16'h0000, 1, 8'h50, 0, 0);
        cycle(0, 8'h00, 16'h0000, 1, 8'h50, 0, 0);
        do_reset();
        idle(3);

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].wr, tbl[i].wa, tbl[i].d, tbl[i].rd, tbl[i].ra, 0, 0);
            chk($sformatf("tbl%0d_valid", i), bus.rd_valid, tbl[i].ev);
            if (tbl[i].cd) chk($sformatf("tbl%0d_dout", i), bus.dout, tbl[i].ed);
        end

        // parity injection and repair
        cycle(1, 8'h30, 16'h0001, 0, 8'h00, 0, 1);
        cycle(0, 8'h00, 16'h0000, 1, 8'h30, 0, 0);
        idle(2);
        chk("par_inj_err", bus.par_err, PAR);
        cycle(1, 8'h30, 16'h0001, 0, 8'h00, 0, 0);
        cycle(0, 8'h00, 16'h0000, 1, 8'h30, 0, 0);
        idle(2);
        chk("par_fix_err", bus.par_err, 1'b0);

        // fill, clear, ignored traffic during busy
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 16'hFFFF, 0, 8'h00, 0, 0);
        cycle(0, 8'h00, 16'h0000, 1, 8'h05, 1, 0);
        n = 0;
        for (int i = 0; i < 300 && bus.busy; i++) begin
            n++;
            cycle(1, 8'h05, 16'hBEEF, 1, 8'h05, 0, 0);
        end
        chk("busy_len", n, DEPTH);
        chk("pre_clear_read", last_d, 16'hFFFF);
        cycle(0, 8'h00, 16'h0000, 1, 8'h00, 0, 0);
        cycle(0, 8'h00, 16'h0000, 1, 8'h05, 0, 0);
        cycle(0, 8'h00, 16'h0000, 1, 8'hFF, 0, 0);
        chk("clr_00", bus.dout, 16'h0000);
        idle(2);
        chk("clr_ff", bus.dout, 16'h0000);
        chk("clr_ff_valid", bus.rd_valid, 1'b1);

        // reset in the middle of a clear
        cycle(0, 8'h00, 16'h0000, 0, 8'h00, 1, 0);
        idle(99);
        do_reset();
        cycle(1, 8'h40, 16'h7777, 0, 8'h00, 0, 0);
        cycle(0, 8'h00, 16'h0000, 1, 8'h40, 0, 0);
        idle(2);
        chk("post_rst_rd", bus.dout, 16'h7777);

        // randomized traffic with frequent collisions and occasional clears
        for (int i = 0; i < 2500; i++) begin
            cycle($urandom_range(0, 1), 8'($urandom_range(0, 15)), 16'($urandom),
                  $urandom_range(0, 1), 8'($urandom_range(0, 15)),
                  $urandom_range(0, 599) == 0, $urandom_range(0, 7) == 0);
        end
        idle(DEPTH + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
